// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-drive and response channels of the ALU command
// sequencer. The sequencer takes the slave view; the host and the ALU
// together form the master side.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;

  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_error;
  logic [CNT_W-1:0] op_count;

  // Host plus combinational ALU.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output alu_out, alu_carry, alu_zero,
    input  cmd_ready, alu_control, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_error, op_count
  );

  // The sequencer itself.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  alu_out, alu_carry, alu_zero,
    output cmd_ready, alu_control, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_error, op_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU: accepts one command, holds the ALU inputs
// for a settle cycle, captures the result and returns it on a response channel.
// Supports chaining of the last successful result and rejects illegal opcodes.
module alu_cmd_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;

  logic [3:0]       r_alu_control;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_last_result;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_zero;
  logic             r_rsp_error;
  logic [CNT_W-1:0] r_op_count;

  logic             w_op_legal;
  logic             w_load_ok;
  logic             w_load_err;
  logic             w_capture;
  logic             w_rsp_done;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0110, 4'b0111, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign w_op_legal = op_is_legal(bus.cmd_op);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and single-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_load_ok    = 1'b0;
    w_load_err   = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (w_op_legal) begin
            w_load_ok    = 1'b1;
            w_state_next = S_ISSUE;
          end else begin
            w_load_err   = 1'b1;
            w_state_next = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        w_capture    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ALU drive registers, response capture, chaining source and op counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_control <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_last_result <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_carry   <= 1'b0;
      r_rsp_zero    <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_op_count    <= '0;
    end else begin
      if (w_load_ok) begin
        r_alu_control <= bus.cmd_op;
        r_alu_b       <= bus.cmd_b;
        r_alu_a       <= bus.cmd_chain ? r_last_result : bus.cmd_a;
      end
      // Illegal opcodes skip the ALU entirely and answer after one edge.
      if (w_load_err) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= '0;
        r_rsp_carry  <= 1'b0;
        r_rsp_zero   <= 1'b0;
        r_rsp_error  <= 1'b1;
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= bus.alu_out;
        r_rsp_carry  <= bus.alu_carry;
        r_rsp_zero   <= bus.alu_zero;
        r_rsp_error  <= 1'b0;
      end
      // Only consumed successful responses feed chaining and the counter.
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        if (!r_rsp_error) begin
          r_last_result <= r_rsp_result;
          r_op_count    <= r_op_count + CNT_ONE;
        end
      end
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.alu_control = r_alu_control;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_carry   = r_rsp_carry;
  assign bus.rsp_zero    = r_rsp_zero;
  assign bus.rsp_error   = r_rsp_error;
  assign bus.op_count    = r_op_count;

endmodule
